and_gate_core: RTL and testbench

Two-input logical AND primitive for the combinational-logic library. Output `Y` is the pure combinational AND of `A` and `B`. A clocked observation layer is wrapped around it to support bring-up and self-checking in larger designs. This layer provides a registered copy of `Y`, a rising-edge pulse, input-combination coverage flags and per-combination saturating occupancy counters.

---
 rtl/and_gate_pkg.sv | 22 ++
 rtl/and_gate_sat_cnt.sv | 32 +++
 rtl/and_gate_core.sv | 72 +++++++
 tb/tb_and_gate_core.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/and_gate_pkg.sv
// ============================================================================
// Module      : and_gate_pkg
// Description : Shared constants for the and_gate_core observation layer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package and_gate_pkg;

  localparam logic [1:0] IDX_00    = 2'd0;
  localparam logic [1:0] IDX_01    = 2'd1;
  localparam logic [1:0] IDX_10    = 2'd2;
  localparam logic [1:0] IDX_11    = 2'd3;
  localparam int         CNT_W_DEF = 8;

  function automatic logic [1:0] combo_idx(input logic a, input logic b);
    return {a, b};
  endfunction

endpackage

`default_nettype wire

// File: rtl/and_gate_sat_cnt.sv
// ============================================================================
// Module      : and_gate_sat_cnt
// Description : Saturating up-counter with synchronous clear priority.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module and_gate_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] C_MAX = {W{1'b1}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != C_MAX)) begin
      q <= q + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/and_gate_core.sv
// ============================================================================
// Module      : and_gate_core
// Description : Combinational 2-input AND with registered observation layer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module and_gate_core
  import and_gate_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             A,
  input  logic             B,
  output logic             Y,
  output logic             Y_q,
  output logic             rise,
  output logic [3:0]       seen,
  output logic             all_seen,
  input  logic             cnt_clr,
  input  logic [1:0]       cnt_sel,
  output logic [CNT_W-1:0] cnt
);

  logic [1:0]       w_idx;
  logic [CNT_W-1:0] w_cnt [4];

  // Y stays purely combinational so it is valid even while held in reset.
  assign Y     = A & B;
  assign w_idx = combo_idx(A, B);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Y_q  <= 1'b0;
      rise <= 1'b0;
    end else begin
      Y_q  <= Y;
      rise <= Y & ~Y_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen <= 4'b0000;
    end else if (cnt_clr) begin
      seen <= 4'b0000;
    end else begin
      seen[w_idx] <= 1'b1;
    end
  end

  assign all_seen = &seen;

  for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
    and_gate_sat_cnt #(
      .W (CNT_W)
    ) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .inc   (w_idx == 2'(gi)),
      .q     (w_cnt[gi])
    );
  end

  assign cnt = w_cnt[cnt_sel];

endmodule

`default_nettype wire

// File: tb/tb_and_gate_core.sv
// ============================================================================
// Module      : tb_and_gate_core
// Description : Self-checking bench for and_gate_core (CNT_W = 2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_and_gate_core;

  localparam int TB_CNT_W = 2;
  localparam int C_MAX    = (1 << TB_CNT_W) - 1;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                A, B;
  logic                Y, Y_q, rise, all_seen;
  logic [3:0]          seen;
  logic                cnt_clr;
  logic [1:0]          cnt_sel;
  logic [TB_CNT_W-1:0] cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state, in plain integers
  int m_cnt [4];
  int m_seen [4];
  int m_yq;
  int m_rise;

  and_gate_core #(
    .CNT_W (TB_CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .A        (A),
    .B        (B),
    .Y        (Y),
    .Y_q      (Y_q),
    .rise     (rise),
    .seen     (seen),
    .all_seen (all_seen),
    .cnt_clr  (cnt_clr),
    .cnt_sel  (cnt_sel),
    .cnt      (cnt)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] model_seen();
    logic [3:0] v;
    for (int k = 0; k < 4; k++) v[k] = (m_seen[k] != 0);
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        m_cnt[k]  = 0;
        m_seen[k] = 0;
      end
      m_yq   = 0;
      m_rise = 0;
    end else begin
      int ab;
      int idx;
      ab     = (A && B) ? 1 : 0;
      idx    = (A ? 2 : 0) + (B ? 1 : 0);
      m_rise = (ab == 1 && m_yq == 0) ? 1 : 0;
      m_yq   = ab;
      if (cnt_clr) begin
        for (int k = 0; k < 4; k++) begin
          m_cnt[k]  = 0;
          m_seen[k] = 0;
        end
      end else begin
        m_seen[idx] = 1;
        if (m_cnt[idx] < C_MAX) m_cnt[idx] = m_cnt[idx] + 1;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("y_cyc",        32'(Y),        32'((A && B) ? 1 : 0));
    chk("y_q_cyc",      32'(Y_q),      32'(m_yq));
    chk("rise_cyc",     32'(rise),     32'(m_rise));
    chk("seen_cyc",     32'(seen),     32'(model_seen()));
    chk("all_seen_cyc", 32'(all_seen), 32'((model_seen() == 4'hF) ? 1 : 0));
    chk("cnt_cyc",      32'(cnt),      32'(m_cnt[cnt_sel]));
  end

  // Apply inputs, take one edge, land 2 time units after it
  task automatic step(input logic a, input logic b, input logic clr);
    A       = a;
    B       = b;
    cnt_clr = clr;
    @(posedge clk);
    #2;
  endtask

  task automatic chk_all_cnt(input string name, input int e0, input int e1, input int e2, input int e3);
    int exp_v [4];
    exp_v[0] = e0; exp_v[1] = e1; exp_v[2] = e2; exp_v[3] = e3;
    for (int s = 0; s < 4; s++) begin
      cnt_sel = 2'(s);
      #1;
      chk(name, 32'(cnt), 32'(exp_v[s]));
    end
    cnt_sel = 2'd0;
  endtask

  initial begin
    rst_n   = 1'b0;
    A       = 1'b0;
    B       = 1'b0;
    cnt_clr = 1'b0;
    cnt_sel = 2'd0;
    @(posedge clk);
    #2;

    // Combinational sweep while state is held in reset
    A = 0; B = 0; #1 chk("sweep_00", 32'(Y), 32'd0);
    A = 0; B = 1; #1 chk("sweep_01", 32'(Y), 32'd0);
    A = 1; B = 0; #1 chk("sweep_10", 32'(Y), 32'd0);
    A = 1; B = 1; #1 chk("sweep_11", 32'(Y), 32'd1);
    chk("rst_y_q",      32'(Y_q),      32'd0);
    chk("rst_rise",     32'(rise),     32'd0);
    chk("rst_seen",     32'(seen),     32'd0);
    chk("rst_all_seen", 32'(all_seen), 32'd0);
    chk("rst_cnt",      32'(cnt),      32'd0);
    A = 0; B = 0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Coverage build-up, ending on the first 1 at Y_q
    step(0, 0, 0); chk("seen_1", 32'(seen), 32'b0001);
    step(0, 1, 0); chk("seen_2", 32'(seen), 32'b0011);
    step(1, 0, 0); chk("seen_3", 32'(seen), 32'b0111);
    chk("all_seen_3", 32'(all_seen), 32'd0);
    step(1, 1, 0); chk("seen_4", 32'(seen), 32'b1111);
    chk("all_seen_4", 32'(all_seen), 32'd1);
    chk("y_q_first",  32'(Y_q),  32'd1);
    chk("rise_first", 32'(rise), 32'd1);
    step(1, 1, 0);
    chk("y_q_hold",  32'(Y_q),  32'd1);
    chk("rise_hold", 32'(rise), 32'd0);
    chk_all_cnt("cnt_cov", 1, 1, 1, 2);

    // Clear wins over the sample at 11, Y_q/rise still follow
    step(0, 0, 0);
    chk("y_q_low", 32'(Y_q), 32'd0);
    step(1, 1, 1);
    cnt_clr = 1'b0;
    chk("clr_seen", 32'(seen), 32'd0);
    chk("clr_y_q",  32'(Y_q),  32'd1);
    chk("clr_rise", 32'(rise), 32'd1);
    chk_all_cnt("clr_cnt", 0, 0, 0, 0);

    // Saturation at 2**CNT_W-1
    for (int n = 0; n < 5; n++) step(1, 0, 0);
    chk_all_cnt("sat_cnt", 0, 0, 3, 0);
    chk("sat_seen", 32'(seen), 32'b0100);

    // Async reset between edges
    step(1, 1, 0);
    chk("pre_rst_rise", 32'(rise), 32'd1);
    cnt_sel = 2'd2;
    rst_n   = 1'b0;
    #1;
    chk("arst_y_q",  32'(Y_q),  32'd0);
    chk("arst_rise", 32'(rise), 32'd0);
    chk("arst_seen", 32'(seen), 32'd0);
    chk("arst_cnt",  32'(cnt),  32'd0);
    chk("arst_y_1",  32'(Y),    32'd1);
    A = 1'b0;
    #1;
    chk("arst_y_0",  32'(Y),    32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step(1, 1, 0);
    chk("post_rst_y_q",  32'(Y_q),  32'd1);
    chk("post_rst_seen", 32'(seen), 32'b1000);
    step(0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
